// File: rtl/mips_multicycle_ctrl.sv
// Multicycle MIPS control unit: registered state machine sequencing a shared-memory datapath,
// with optional memory wait-states, a retired-instruction counter and illegal-opcode flagging.
module mips_multicycle_ctrl #(
    parameter bit          MEM_WAIT = 1'b1,
    parameter int unsigned CNT_W    = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [5:0]       op,
    input  logic [5:0]       funct,
    input  logic             zero,
    input  logic             memready,
    output logic             iord,
    output logic             memread,
    output logic             memwrite,
    output logic             irwrite,
    output logic             pcwrite,
    output logic             regwrite,
    output logic [1:0]       regdst,
    output logic [1:0]       memtoreg,
    output logic             alusrca,
    output logic [1:0]       alusrcb,
    output logic             signext,
    output logic             shiftl16,
    output logic [1:0]       pcsrc,
    output logic [3:0]       alucontrol,
    output logic             retired,
    output logic [CNT_W-1:0] instr_count,
    output logic             illegal
);

    localparam logic [5:0] OpRtype = 6'b000000, OpLw   = 6'b100011, OpSw    = 6'b101011;
    localparam logic [5:0] OpBeq   = 6'b000100, OpBne  = 6'b000101, OpAddi  = 6'b001000;
    localparam logic [5:0] OpAddiu = 6'b001001, OpOri  = 6'b001101, OpSlti  = 6'b001010;
    localparam logic [5:0] OpLui   = 6'b001111, OpJ    = 6'b000010, OpJal   = 6'b000011;
    localparam logic [5:0] FnJr    = 6'b001000, FnAdd  = 6'b100000, FnAddu  = 6'b100001;
    localparam logic [5:0] FnSub   = 6'b100010, FnSubu = 6'b100011, FnAnd   = 6'b100100;
    localparam logic [5:0] FnOr    = 6'b100101, FnSlt  = 6'b101010, FnSltu  = 6'b101011;
    localparam logic [3:0] AluAdd  = 4'b0010,   AluSub = 4'b1010,   AluAnd  = 4'b0000;
    localparam logic [3:0] AluOr   = 4'b0001,   AluSlt = 4'b1011,   AluSltu = 4'b1111;

    typedef enum logic [3:0] {
        StFetch, StDecode, StMemAdr, StMemRd, StMemWb, StMemWr, StRtypeEx,
        StRtypeWb, StBranch, StImmEx, StImmWb, StJump, StJrEx
    } state_e;

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             ready;

    always_comb begin
        ready      = MEM_WAIT ? memready : 1'b1;
        state_d    = state_q;
        iord       = 1'b0;
        memread    = 1'b0;
        memwrite   = 1'b0;
        irwrite    = 1'b0;
        pcwrite    = 1'b0;
        regwrite   = 1'b0;
        regdst     = 2'b00;
        memtoreg   = 2'b00;
        alusrca    = 1'b0;
        alusrcb    = 2'b00;
        signext    = 1'b0;
        shiftl16   = 1'b0;
        pcsrc      = 2'b00;
        alucontrol = 4'b0000;
        retired    = 1'b0;
        illegal    = 1'b0;
        case (state_q)
            StFetch: begin
                memread    = 1'b1;
                alusrcb    = 2'b01;
                alucontrol = AluAdd;
                if (ready) begin
                    irwrite = 1'b1;
                    pcwrite = 1'b1;
                    state_d = StDecode;
                end
            end
            StDecode: begin
                // ALUOut captures the branch target speculatively
                alusrcb    = 2'b11;
                alucontrol = AluAdd;
                case (op)
                    OpLw, OpSw:                             state_d = StMemAdr;
                    OpRtype: state_d = (funct == FnJr) ? StJrEx : StRtypeEx;
                    OpBeq, OpBne:                           state_d = StBranch;
                    OpAddi, OpAddiu, OpOri, OpSlti, OpLui:  state_d = StImmEx;
                    OpJ, OpJal:                             state_d = StJump;
                    default: begin
                        illegal = 1'b1;
                        state_d = StFetch;
                    end
                endcase
            end
            StMemAdr: begin
                alusrca    = 1'b1;
                alusrcb    = 2'b10;
                signext    = 1'b1;
                alucontrol = AluAdd;
                state_d    = (op == OpSw) ? StMemWr : StMemRd;
            end
            StMemRd: begin
                iord    = 1'b1;
                memread = 1'b1;
                if (ready) state_d = StMemWb;
            end
            StMemWb: begin
                regwrite = 1'b1;
                memtoreg = 2'b01;
                retired  = 1'b1;
                state_d  = StFetch;
            end
            StMemWr: begin
                iord     = 1'b1;
                memwrite = 1'b1;
                if (ready) begin
                    retired = 1'b1;
                    state_d = StFetch;
                end
            end
            StRtypeEx: begin
                alusrca = 1'b1;
                state_d = StRtypeWb;
                case (funct)
                    FnAdd, FnAddu: alucontrol = AluAdd;
                    FnSub, FnSubu: alucontrol = AluSub;
                    FnAnd:         alucontrol = AluAnd;
                    FnOr:          alucontrol = AluOr;
                    FnSlt:         alucontrol = AluSlt;
                    FnSltu:        alucontrol = AluSltu;
                    default: begin
                        illegal = 1'b1;
                        state_d = StFetch;
                    end
                endcase
            end
            StRtypeWb: begin
                regwrite = 1'b1;
                regdst   = 2'b01;
                retired  = 1'b1;
                state_d  = StFetch;
            end
            StBranch: begin
                alusrca    = 1'b1;
                alucontrol = AluSub;
                pcsrc      = 2'b01;
                pcwrite    = (op == OpBne) ? ~zero : zero;
                retired    = 1'b1;
                state_d    = StFetch;
            end
            StImmEx: begin
                // LUI relies on rs = r0 so A contributes nothing to the sum
                alusrca = 1'b1;
                alusrcb = 2'b10;
                state_d = StImmWb;
                case (op)
                    OpOri:  alucontrol = AluOr;
                    OpSlti: begin
                        signext    = 1'b1;
                        alucontrol = AluSlt;
                    end
                    OpLui: begin
                        shiftl16   = 1'b1;
                        alucontrol = AluAdd;
                    end
                    default: begin
                        signext    = 1'b1;
                        alucontrol = AluAdd;
                    end
                endcase
            end
            StImmWb: begin
                regwrite = 1'b1;
                retired  = 1'b1;
                state_d  = StFetch;
            end
            StJump: begin
                pcsrc   = 2'b10;
                pcwrite = 1'b1;
                retired = 1'b1;
                state_d = StFetch;
                if (op == OpJal) begin
                    regwrite = 1'b1;
                    regdst   = 2'b10;
                    memtoreg = 2'b10;
                end
            end
            StJrEx: begin
                pcsrc   = 2'b11;
                pcwrite = 1'b1;
                retired = 1'b1;
                state_d = StFetch;
            end
            default: state_d = StFetch;
        endcase
        // Reset must not let any partial transfer or writeback complete
        if (reset) begin
            memread  = 1'b0;
            memwrite = 1'b0;
            irwrite  = 1'b0;
            pcwrite  = 1'b0;
            regwrite = 1'b0;
            retired  = 1'b0;
            illegal  = 1'b0;
        end
        cnt_d = retired ? cnt_q + CNT_W'(1) : cnt_q;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= StFetch;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    assign instr_count = cnt_q;

endmodule

// File: tb/tb_mips_multicycle_ctrl.sv
// Randomized bench: an instruction-level model walks each instruction's phases and predicts
// the full control word every cycle; a 4-bit counter instance checks wrap-around.
module tb_mips_multicycle_ctrl;

    localparam logic [5:0] OpRtype = 6'b000000, OpLw   = 6'b100011, OpSw    = 6'b101011;
    localparam logic [5:0] OpBeq   = 6'b000100, OpBne  = 6'b000101, OpAddi  = 6'b001000;
    localparam logic [5:0] OpAddiu = 6'b001001, OpOri  = 6'b001101, OpSlti  = 6'b001010;
    localparam logic [5:0] OpLui   = 6'b001111, OpJ    = 6'b000010, OpJal   = 6'b000011;
    localparam logic [5:0] FnJr    = 6'b001000;
    localparam logic [3:0] AluAdd  = 4'b0010, AluSub = 4'b1010, AluOr = 4'b0001, AluSlt = 4'b1011;

    typedef struct packed {
        logic       iord, memread, memwrite, irwrite, pcwrite, regwrite;
        logic [1:0] regdst, memtoreg;
        logic       alusrca;
        logic [1:0] alusrcb;
        logic       signext, shiftl16;
        logic [1:0] pcsrc;
        logic [3:0] alucontrol;
        logic       retired, illegal;
    } ctl_t;

    logic        clk = 1'b0;
    logic        reset, zero, memready;
    logic [5:0]  op, funct;

    logic        iord, memread, memwrite, irwrite, pcwrite, regwrite, alusrca, signext;
    logic        shiftl16, retired, illegal;
    logic [1:0]  regdst, memtoreg, alusrcb, pcsrc;
    logic [3:0]  alucontrol;
    logic [31:0] instr_count;

    logic        iord4, memread4, memwrite4, irwrite4, pcwrite4, regwrite4, alusrca4, signext4;
    logic        shiftl164, retired4, illegal4;
    logic [1:0]  regdst4, memtoreg4, alusrcb4, pcsrc4;
    logic [3:0]  alucontrol4;
    logic [3:0]  instr_count4;

    ctl_t obs, obs4;
    assign obs  = {iord, memread, memwrite, irwrite, pcwrite, regwrite, regdst, memtoreg,
                   alusrca, alusrcb, signext, shiftl16, pcsrc, alucontrol, retired, illegal};
    assign obs4 = {iord4, memread4, memwrite4, irwrite4, pcwrite4, regwrite4, regdst4, memtoreg4,
                   alusrca4, alusrcb4, signext4, shiftl164, pcsrc4, alucontrol4, retired4,
                   illegal4};

    int unsigned n_vec = 0;
    int unsigned n_err = 0;
    int unsigned model_cnt = 0;

    always #5 clk = ~clk;

    mips_multicycle_ctrl #(.MEM_WAIT(1'b1), .CNT_W(32)) u_dut (
        .clk(clk), .reset(reset), .op(op), .funct(funct), .zero(zero), .memready(memready),
        .iord(iord), .memread(memread), .memwrite(memwrite), .irwrite(irwrite),
        .pcwrite(pcwrite), .regwrite(regwrite), .regdst(regdst), .memtoreg(memtoreg),
        .alusrca(alusrca), .alusrcb(alusrcb), .signext(signext), .shiftl16(shiftl16),
        .pcsrc(pcsrc), .alucontrol(alucontrol), .retired(retired),
        .instr_count(instr_count), .illegal(illegal)
    );

    mips_multicycle_ctrl #(.MEM_WAIT(1'b1), .CNT_W(4)) u_dut4 (
        .clk(clk), .reset(reset), .op(op), .funct(funct), .zero(zero), .memready(memready),
        .iord(iord4), .memread(memread4), .memwrite(memwrite4), .irwrite(irwrite4),
        .pcwrite(pcwrite4), .regwrite(regwrite4), .regdst(regdst4), .memtoreg(memtoreg4),
        .alusrca(alusrca4), .alusrcb(alusrcb4), .signext(signext4), .shiftl16(shiftl164),
        .pcsrc(pcsrc4), .alucontrol(alucontrol4), .retired(retired4),
        .instr_count(instr_count4), .illegal(illegal4)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic bit legal_op(input logic [5:0] o);
        return o inside {OpRtype, OpLw, OpSw, OpBeq, OpBne, OpAddi, OpAddiu, OpOri, OpSlti,
                         OpLui, OpJ, OpJal};
    endfunction

    // {valid, alucontrol} for an R-type funct (JR handled separately)
    function automatic logic [4:0] rtype_alu(input logic [5:0] f);
        case (f)
            6'b100000, 6'b100001: return 5'b10010;
            6'b100010, 6'b100011: return 5'b11010;
            6'b100100:            return 5'b10000;
            6'b100101:            return 5'b10001;
            6'b101010:            return 5'b11011;
            6'b101011:            return 5'b11111;
            default:              return 5'b00000;
        endcase
    endfunction

    function automatic ctl_t mask(input ctl_t e);
        ctl_t m = e;
        m.memread  = 1'b0;
        m.memwrite = 1'b0;
        m.irwrite  = 1'b0;
        m.pcwrite  = 1'b0;
        m.regwrite = 1'b0;
        m.retired  = 1'b0;
        m.illegal  = 1'b0;
        return m;
    endfunction

    task automatic step(input string tag, input ctl_t e, input logic mr, input logic z);
        memready = mr;
        zero     = z;
        #1;
        check(tag, 32'(obs), 32'(e));
        check({tag, "_w4"}, 32'(obs4), 32'(e));
        check({tag, "_cnt"}, instr_count, model_cnt);
        check({tag, "_cnt4"}, 32'(instr_count4), model_cnt % 16);
        if (e.retired) model_cnt++;
        @(posedge clk);
        #1;
    endtask

    task automatic run_instr(input logic [5:0] o, input logic [5:0] f, input logic z,
                             input int fw, input int mw, input bit abort_wr);
        ctl_t       e;
        logic [4:0] rf;
        op    = o;
        funct = f;
        for (int i = 0; i <= fw; i++) begin
            e = '0;
            e.memread = 1'b1; e.alusrcb = 2'b01; e.alucontrol = AluAdd;
            e.irwrite = (i == fw); e.pcwrite = (i == fw);
            step("fetch", e, (i == fw), 1'($urandom));
        end
        e = '0;
        e.alusrcb = 2'b11; e.alucontrol = AluAdd; e.illegal = !legal_op(o);
        step("decode", e, 1'($urandom), 1'($urandom));
        if (!legal_op(o)) return;
        if (o == OpLw || o == OpSw) begin
            e = '0;
            e.alusrca = 1'b1; e.alusrcb = 2'b10; e.signext = 1'b1; e.alucontrol = AluAdd;
            step("memadr", e, 1'($urandom), 1'($urandom));
            if (o == OpLw) begin
                for (int i = 0; i <= mw; i++) begin
                    e = '0;
                    e.iord = 1'b1; e.memread = 1'b1;
                    step("memrd", e, (i == mw), 1'($urandom));
                end
                e = '0;
                e.regwrite = 1'b1; e.memtoreg = 2'b01; e.retired = 1'b1;
                step("memwb", e, 1'($urandom), 1'($urandom));
            end else begin
                for (int i = 0; i <= mw; i++) begin
                    e = '0;
                    e.iord = 1'b1; e.memwrite = 1'b1;
                    if (abort_wr) begin
                        reset = 1'b1;
                        step("wr_rst", mask(e), 1'b0, 1'($urandom));
                        reset = 1'b0;
                        model_cnt = 0;
                        return;
                    end
                    e.retired = (i == mw);
                    step("memwr", e, (i == mw), 1'($urandom));
                end
            end
        end else if (o == OpRtype && f == FnJr) begin
            e = '0;
            e.pcsrc = 2'b11; e.pcwrite = 1'b1; e.retired = 1'b1;
            step("jrex", e, 1'($urandom), 1'($urandom));
        end else if (o == OpRtype) begin
            rf = rtype_alu(f);
            e = '0;
            e.alusrca = 1'b1; e.alucontrol = rf[3:0]; e.illegal = !rf[4];
            step("rtypeex", e, 1'($urandom), 1'($urandom));
            if (!rf[4]) return;
            e = '0;
            e.regwrite = 1'b1; e.regdst = 2'b01; e.retired = 1'b1;
            step("rtypewb", e, 1'($urandom), 1'($urandom));
        end else if (o == OpBeq || o == OpBne) begin
            e = '0;
            e.alusrca = 1'b1; e.alucontrol = AluSub; e.pcsrc = 2'b01; e.retired = 1'b1;
            e.pcwrite = (o == OpBeq) ? z : !z;
            step("branch", e, 1'($urandom), z);
        end else if (o == OpJ || o == OpJal) begin
            e = '0;
            e.pcsrc = 2'b10; e.pcwrite = 1'b1; e.retired = 1'b1;
            if (o == OpJal) begin
                e.regwrite = 1'b1; e.regdst = 2'b10; e.memtoreg = 2'b10;
            end
            step("jump", e, 1'($urandom), 1'($urandom));
        end else begin
            e = '0;
            e.alusrca = 1'b1; e.alusrcb = 2'b10;
            e.signext    = (o == OpAddi || o == OpAddiu || o == OpSlti);
            e.shiftl16   = (o == OpLui);
            e.alucontrol = (o == OpOri) ? AluOr : (o == OpSlti) ? AluSlt : AluAdd;
            step("immex", e, 1'($urandom), 1'($urandom));
            e = '0;
            e.regwrite = 1'b1; e.retired = 1'b1;
            step("immwb", e, 1'($urandom), 1'($urandom));
        end
    endtask

    logic [5:0] op_tab [12] = '{OpRtype, OpLw, OpSw, OpBeq, OpBne, OpAddi, OpAddiu, OpOri,
                                OpSlti, OpLui, OpJ, OpJal};
    logic [5:0] fn_tab [9]  = '{6'b100000, 6'b100001, 6'b100010, 6'b100011, 6'b100100,
                                6'b100101, 6'b101010, 6'b101011, 6'b001000};

    initial begin
        ctl_t       e;
        logic [5:0] o, f;
        reset = 1'b1; zero = 1'b0; memready = 1'b1; op = '0; funct = '0;
        @(posedge clk);
        #1;
        e = '0;
        e.alusrcb = 2'b01; e.alucontrol = AluAdd;
        step("reset", e, 1'b1, 1'b0);
        reset = 1'b0;

        run_instr(OpLw, 6'h00, 1'b0, 0, 0, 1'b0);
        run_instr(OpLw, 6'h00, 1'b0, 3, 2, 1'b0);
        run_instr(OpBeq, 6'h00, 1'b1, 0, 0, 1'b0);
        run_instr(OpBne, 6'h00, 1'b1, 0, 0, 1'b0);
        run_instr(OpJal, 6'h00, 1'b0, 0, 0, 1'b0);
        run_instr(OpRtype, FnJr, 1'b0, 0, 0, 1'b0);
        run_instr(6'b111111, 6'h00, 1'b0, 0, 0, 1'b0);
        run_instr(OpRtype, 6'b000111, 1'b0, 0, 0, 1'b0);
        run_instr(OpSw, 6'h00, 1'b0, 1, 2, 1'b0);
        run_instr(OpSw, 6'h00, 1'b0, 0, 2, 1'b1);
        for (int i = 0; i < 16; i++) run_instr(OpJ, 6'h00, 1'b0, 0, 0, 1'b0);
        #1;
        check("wrap_cnt4", 32'(instr_count4), 32'd0);
        check("wrap_cnt32", instr_count, 32'd16);

        for (int i = 0; i < 300; i++) begin
            o = ($urandom_range(0, 9) == 0) ? 6'($urandom) : op_tab[$urandom_range(0, 11)];
            f = ($urandom_range(0, 9) == 0) ? 6'($urandom) : fn_tab[$urandom_range(0, 8)];
            run_instr(o, f, 1'($urandom),
                      ($urandom_range(0, 3) == 0) ? $urandom_range(1, 3) : 0,
                      ($urandom_range(0, 3) == 0) ? $urandom_range(1, 3) : 0,
                      (o == OpSw) && ($urandom_range(0, 19) == 0));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "time limit");
    end

endmodule

// File: doc/mips_multicycle_ctrl.md
Name: mips_multicycle_ctrl

Overview:
- Parametrised multicycle control unit for the next-generation MIPS core; replaces the single-cycle controller/maindec/aludec path.
- Drives a shared-memory, shared-ALU datapath (IR, MDR, A, B, ALUOut registers) through a registered state machine.
- Supports optional memory wait-states via a ready handshake, plus a retired-instruction counter and illegal-opcode flagging.
- Instruction set: R-type (ADD/ADDU/SUB/SUBU/AND/OR/SLT/SLTU/JR), LW, SW, BEQ, BNE, ADDI, ADDIU, ORI, SLTI, LUI, J, JAL.

Parameters:
MEM_WAIT, 1, 1: FETCH/MEMRD/MEMWR stall until memready=1; 0: memready ignored, each memory state lasts one cycle
CNT_W, 32, width of retired-instruction counter

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-high reset
op  in  6  IR[31:26]
funct  in  6  IR[5:0]
zero  in  1  ALU zero flag, current cycle
memready  in  1  memory access completes this cycle
iord  out  1  memory address: 0 = PC, 1 = ALUOut
memread  out  1  memory read request
memwrite  out  1  memory write strobe
irwrite  out  1  load IR (and MDR)
pcwrite  out  1  load PC (already gated by condition)
regwrite  out  1  register-file write enable
regdst  out  2  00 rt, 01 rd, 10 r31
memtoreg  out  2  00 ALUOut, 01 MDR, 10 PC
alusrca  out  1  0 PC, 1 A
alusrcb  out  2  00 B, 01 const 4, 10 ext/shifted imm, 11 sign imm<<2
signext  out  1  1 sign-extend, 0 zero-extend imm
shiftl16  out  1  imm<<16 (LUI)
pcsrc  out  2  00 ALU result, 01 ALUOut, 10 jump target, 11 A (JR)
alucontrol  out  4  0010 add, 1010 sub, 0000 and, 0001 or, 1011 slt, 1111 sltu
retired  out  1  one-cycle pulse in final state of each instruction
instr_count  out  CNT_W  retired-instruction count
illegal  out  1  one-cycle pulse on undecodable op/funct

Behaviour:
- State register, synchronous reset to FETCH. Outputs are combinational from the state, except gating by memready and zero.
- While reset=1, all enables (memread, memwrite, irwrite, pcwrite, regwrite, retired, illegal) are forced 0.
- instr_count resets to 0 and increments on each retired pulse; wraps at 2^CNT_W-1 -> 0.
- FETCH: iord=0, memread=1, alusrca=0, alusrcb=01, add, pcsrc=00.
  - irwrite and pcwrite assert only in the cycle memready=1 (always when MEM_WAIT=0); that cycle -> DECODE, otherwise stay.
- DECODE: alusrca=0, alusrcb=11, add (branch target into ALUOut). Next state by op:
  - LW/SW -> MEMADR
  - R-type -> JREX if funct=001000, else RTYPEEX
  - BEQ/BNE -> BRANCH
  - ADDI/ADDIU/ORI/SLTI/LUI -> IMMEX
  - J/JAL -> JUMP
  - unknown op -> FETCH with illegal=1
- MEMADR: alusrca=1, alusrcb=10, signext=1, add. -> MEMRD (LW) or MEMWR (SW).
- MEMRD: iord=1, memread=1. On memready -> MEMWB.
- MEMWB: regwrite=1, regdst=00, memtoreg=01, retired=1. -> FETCH.
- MEMWR: iord=1, memwrite=1, asserted every cycle while waiting; on memready retired=1 -> FETCH.
- RTYPEEX: alusrca=1, alusrcb=00, alucontrol from funct.
  - Unknown funct -> FETCH with illegal=1, no writeback.
  - Otherwise -> RTYPEWB.
- RTYPEWB: regwrite=1, regdst=01, memtoreg=00, retired=1. -> FETCH.
- BRANCH: alusrca=1, alusrcb=00, sub, pcsrc=01, retired=1.
  - pcwrite = zero for BEQ, ~zero for BNE.
  - -> FETCH.
- IMMEX: alusrca=1, alusrcb=10.
  - ADDI/ADDIU: signext=1, add.
  - ORI: signext=0, or.
  - SLTI: signext=1, slt.
  - LUI: shiftl16=1, add, with A = r0.
  - -> IMMWB.
- IMMWB: regwrite=1, regdst=00, memtoreg=00, retired=1. -> FETCH.
- JUMP: pcsrc=10, pcwrite=1, retired=1.
  - JAL additionally asserts regwrite=1, regdst=10, memtoreg=10; PC already holds PC+4.
  - -> FETCH.
- JREX: pcsrc=11, pcwrite=1, retired=1. -> FETCH.
- Cycles per instruction, with zero wait-states:
  - LW 5
  - SW, R-type, immediate ops 4
  - BEQ/BNE, J, JAL, JR 3
  - Each memready=0 cycle in a memory state adds 1.
- Unused outputs are driven to 0 (never x) in every state.
- Reset asserted in any state: next cycle is FETCH, no partial write completes, and instr_count is cleared.

Test Plan:
- Reset then LW (op=100011), memready=1 constant -> states FETCH, DECODE, MEMADR, MEMRD, MEMWB; regwrite and memtoreg=01 only in cycle 5; instr_count=1.
- Same LW with memready low for 3 cycles in FETCH and 2 in MEMRD -> 10 cycles total; irwrite/pcwrite pulse exactly once, in the memready cycle; memread held throughout.
- BEQ with zero=1, then BNE with zero=1 -> pcwrite=1 with pcsrc=01 in BRANCH for BEQ; pcwrite=0 for BNE; both 3 cycles; instr_count +2.
- JAL (op=000011) -> JUMP asserts pcwrite=1, pcsrc=10, regwrite=1, regdst=10, memtoreg=10; JR (funct=001000) -> pcsrc=11, regwrite=0.
- op=111111 -> illegal pulses in DECODE, returns to FETCH, instr_count unchanged; R-type funct=000111 -> illegal in RTYPEEX, regwrite never asserts.
- Reset asserted during MEMWR with memready=0 -> memwrite drops that cycle, state FETCH, instr_count=0; CNT_W=4 with 16 retired ops -> counter wraps to 0.
